bin_to_bcd: RTL and testbench



---
 rtl/bin_to_bcd.sv | 105 ++++++++++
 tb/tb_bin_to_bcd.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble binary to four-digit BCD converter
// Optional busy output when BIN2BCD_BUSY_EN is defined.
module bin_to_bcd #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] bin,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0,
`ifdef BIN2BCD_BUSY_EN
    output logic         busy,
`endif
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    sreg;
    logic [15:0]     acc;
    logic [15:0]     acc_adj;
    logic [15:0]     acc_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic            unused_acc_msb;

    assign accept = start && (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == CNT_LAST);

    // All four digits are corrected from the pre-shift value before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_nxt        = {acc_adj[14:0], sreg[N-1]};
    assign unused_acc_msb = acc_adj[15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (start) state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
`ifdef BIN2BCD_BUSY_EN
        busy = (state == SHIFT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
            bcd3 <= '0;
            bcd2 <= '0;
            bcd1 <= '0;
            bcd0 <= '0;
        end else if (accept) begin
            sreg <= bin;
            acc  <= '0;
            cnt  <= CNT_INIT;
        end else if (state == SHIFT) begin
            sreg <= sreg << 1;
            acc  <= acc_nxt;
            cnt  <= cnt - CNT_LAST;
            if (last) begin
                {bcd3, bcd2, bcd1, bcd0} <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb/tb_bin_to_bcd.sv - directed-vector bench for bin_to_bcd at N=7 and N=13
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start7 = 1'b0;
    logic [6:0]  bin7 = '0;
    logic [3:0]  a3, a2, a1, a0;
    logic        done7;

    logic        start13 = 1'b0;
    logic [12:0] bin13 = '0;
    logic [3:0]  b3, b2, b1, b0;
    logic        done13;

`ifdef BIN2BCD_BUSY_EN
    logic        busy7;
    logic        busy13;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bin_to_bcd #(.N(7)) dut7 (
        .clk   (clk),
        .rst   (rst),
        .start (start7),
        .bin   (bin7),
        .bcd3  (a3),
        .bcd2  (a2),
        .bcd1  (a1),
        .bcd0  (a0),
`ifdef BIN2BCD_BUSY_EN
        .busy  (busy7),
`endif
        .done  (done7)
    );

    bin_to_bcd #(.N(13)) dut13 (
        .clk   (clk),
        .rst   (rst),
        .start (start13),
        .bin   (bin13),
        .bcd3  (b3),
        .bcd2  (b2),
        .bcd1  (b1),
        .bcd0  (b0),
`ifdef BIN2BCD_BUSY_EN
        .busy  (busy13),
`endif
        .done  (done13)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run7(input string tag, input logic [6:0] v, input logic [15:0] exp);
        int c;
        int nb;
        @(negedge clk);
        start7 = 1'b1;
        bin7   = v;
        @(posedge clk);
        @(negedge clk);
        start7 = 1'b0;
        bin7   = ~v;
        check({tag, "_done_low"}, 32'(done7), 32'd0);
        c  = 0;
        nb = 0;
`ifdef BIN2BCD_BUSY_EN
        if (busy7) nb++;
`endif
        while (!done7 && c < 40) begin
            @(posedge clk);
            @(negedge clk);
            c++;
`ifdef BIN2BCD_BUSY_EN
            if (busy7) nb++;
`endif
        end
        check({tag, "_latency"}, 32'(c), 32'd7);
        check({tag, "_digits"}, 32'({a3, a2, a1, a0}), 32'(exp));
`ifdef BIN2BCD_BUSY_EN
        check({tag, "_busy_cycles"}, 32'(nb), 32'd7);
        check({tag, "_busy_low"}, 32'(busy7), 32'd0);
`endif
    endtask

    task automatic run13(input string tag, input logic [12:0] v, input logic [15:0] exp);
        int c;
        int nb;
        @(negedge clk);
        start13 = 1'b1;
        bin13   = v;
        @(posedge clk);
        @(negedge clk);
        start13 = 1'b0;
        bin13   = ~v;
        c  = 0;
        nb = 0;
`ifdef BIN2BCD_BUSY_EN
        if (busy13) nb++;
`endif
        while (!done13 && c < 60) begin
            @(posedge clk);
            @(negedge clk);
            c++;
`ifdef BIN2BCD_BUSY_EN
            if (busy13) nb++;
`endif
        end
        check({tag, "_latency"}, 32'(c), 32'd13);
        check({tag, "_digits"}, 32'({b3, b2, b1, b0}), 32'(exp));
`ifdef BIN2BCD_BUSY_EN
        check({tag, "_busy_cycles"}, 32'(nb), 32'd13);
`endif
    endtask

    initial begin
        int c;
        logic seen_low;

        #2 rst = 1'b1;
        #1;
        check("rst_done7", 32'(done7), 32'd0);
        check("rst_digits7", 32'({a3, a2, a1, a0}), 32'h0);
        check("rst_done13", 32'(done13), 32'd0);
`ifdef BIN2BCD_BUSY_EN
        check("rst_busy7", 32'(busy7), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run7("b7", 7'd7, 16'h0007);
        run7("b53", 7'd53, 16'h0053);
        run7("b99", 7'd99, 16'h0099);
        run7("b120", 7'd120, 16'h0120);
        run7("b127", 7'd127, 16'h0127);
        run7("b0", 7'd0, 16'h0000);

        // Second start three edges into a conversion must be ignored.
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd99;
        @(posedge clk);
        @(negedge clk);
        start7 = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        start7 = 1'b1;
        bin7   = 7'd5;
        @(posedge clk);
        @(negedge clk);
        start7 = 1'b0;
        c = 3;
        while (!done7 && c < 40) begin @(posedge clk); @(negedge clk); c++; end
        check("ign_latency", 32'(c), 32'd7);
        check("ign_digits", 32'({a3, a2, a1, a0}), 32'h0099);
        repeat (10) @(negedge clk);
        check("ign_done_hold", 32'(done7), 32'd1);
        check("ign_digits_hold", 32'({a3, a2, a1, a0}), 32'h0099);

        // Asynchronous reset three edges into a conversion of 120.
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd120;
        @(posedge clk);
        @(negedge clk);
        start7 = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        check("abort_done", 32'(done7), 32'd0);
        check("abort_digits", 32'({a3, a2, a1, a0}), 32'h0);
`ifdef BIN2BCD_BUSY_EN
        check("abort_busy", 32'(busy7), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run7("b42", 7'd42, 16'h0042);

        // start held high: a new conversion every N+1 edges.
        @(negedge clk);
        start7 = 1'b1;
        bin7   = 7'd53;
        c = 0;
        while (!done7 && c < 40) begin @(posedge clk); @(negedge clk); c++; end
        c = 0;
        seen_low = 1'b0;
        while (c < 40) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (!done7) seen_low = 1'b1;
            else if (seen_low) break;
        end
        check("b2b_period", 32'(c), 32'd8);
        check("b2b_digits", 32'({a3, a2, a1, a0}), 32'h0053);
        start7 = 1'b0;
        c = 0;
        while (!done7 && c < 40) begin @(posedge clk); @(negedge clk); c++; end
        check("b2b_final_done", 32'(done7), 32'd1);

        run13("w8191", 13'd8191, 16'h8191);
        run13("w1000", 13'd1000, 16'h1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
